// File: rtl/spi_controller.sv
// SPI mode-0 write-frame controller: shifts {wr, addr, data} out MSB first,
// sclk half-period of DIV clk cycles, with lead, trail and deselect-gap phases.
module spi_controller #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       wr_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       ncs_o,
  output logic       copi_o
);
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned SHIFT_W = FRAME_W - 1;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } state_e;

  state_e               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  // Bits still to be sent after the one currently on copi.
  logic [SHIFT_W-1:0]   shreg_q, shreg_d;
  logic                 sclk_q, sclk_d;
  logic                 ncs_q, ncs_d;
  logic                 copi_q, copi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 phase_end;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    copi_d    = copi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    phase_end = (phase_q == PH_LAST);

    // Phase counter runs in every non-idle state and wraps at each phase change.
    if (state_q != IDLE) begin
      phase_d = phase_end ? '0 : phase_q + PH_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        if (start_i) begin
          state_d = LEAD;
          phase_d = '0;
          bit_d   = '0;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          copi_d  = wr_i;
          shreg_d = {addr_i, data_i};
        end
      end
      LEAD: begin
        if (phase_end) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = TRAIL;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + BIT_W'(1);
            copi_d  = shreg_q[SHIFT_W-1];
            shreg_d = {shreg_q[SHIFT_W-2:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      TRAIL: begin
        if (phase_end) begin
          state_d = GAP;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
        end
      end
      GAP: begin
        if (phase_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign ncs_o  = ncs_q;
  assign copi_o = copi_q;

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI mode-0 controller that drives the write-frame format consumed by the design's SPI peripheral. Each frame is 16 bits, MSB first: bit 15 = write flag, bits 14:8 = register address, bits 7:0 = data. The block sits on the test-harness or host-logic side. It serializes one frame per `start` request onto `sclk`/`ncs`/`copi`, with `sclk` timing slow enough for the peripheral's 2–3 flop input synchronizers.

## Interface
- `DIV`, default 4: `sclk` half-period in `clk` cycles. Legal range is 2..255. At least 4 is required when the peripheral runs on the same `clk` frequency.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request one frame. Sampled only in IDLE.
- `wr`  input  1  value sent as frame bit 15 (1 = write).
- `addr`  input  7  frame bits 14:8.
- `data`  input  8  frame bits 7:0.
- `busy`  output  1  high from the cycle after accept until the frame completes.
- `done`  output  1  one-cycle pulse at frame completion.
- `sclk`  output  1  serial clock; idles low.
- `ncs`  output  1  active-low chip select; idles high.
- `copi`  output  1  serial data, controller to peripheral.

## Operation
- All outputs are registered.
- Reset values: `sclk`=0, `ncs`=1, `copi`=0, `busy`=0, `done`=0, state=IDLE, counters=0.
- Latching: on accept, {`wr`,`addr`,`data`} is latched into a 16-bit shift register. Input changes after accept have no effect.
- States:
  - **IDLE**: `ncs`=1, `sclk`=0. If `start`=1, go to LEAD and drive `ncs`=0, `copi`=frame[15], `busy`=1.
  - **LEAD**: hold `sclk` low for DIV cycles (setup of bit 15), then go to HIGH.
  - **HIGH**: `sclk`=1 for DIV cycles.
    - If bit counter = 15, go to TRAIL.
    - Otherwise go to LOW, incrementing the bit counter and shifting the next bit onto `copi` on the same edge that drives `sclk`=0.
  - **LOW**: `sclk`=0 for DIV cycles, then go to HIGH.
  - **TRAIL**: `sclk`=0, `ncs`=0 for DIV cycles (hold after the last rising edge), then go to GAP with `ncs`=1.
  - **GAP**: `ncs`=1 for DIV cycles (minimum deselect time), then go to IDLE with `busy`=0 and `done`=1 for one cycle.
- Counters:
  - Phase counter: width `$clog2(DIV)`, counts 0..DIV-1 and wraps at each phase change.
  - Bit counter: 4 bits, counts 0..15, no wrap beyond 15.
- Data changes only while `sclk` is low; the peripheral samples on `sclk` rising edges.
- Exactly 16 `sclk` rising edges occur per frame, all with `ncs`=0.
- Boundary conditions:
  - `start` while `busy`=1 is ignored, not queued.
  - `start`=1 in the same cycle that `done`=1 is accepted, because the state is IDLE.
  - `rst` mid-frame: the next cycle shows reset values and the frame is aborted. The peripheral discards the partial frame because `ncs` rises.
  - `rst` and `start` together: `rst` wins.

## Timing
- Let start be accepted at edge 0:
  - `ncs` falls and `busy` rises after edge 0.
  - First `sclk` rise after edge DIV.
  - Rise k (k=0..15) after edge DIV·(1+2k).
  - Last fall after edge 32·DIV.
  - `ncs` rises after edge 33·DIV.
  - `done`=1 and `busy`=0 after edge 34·DIV.
- `ncs` is low for 33·DIV cycles; `busy` is high for 34·DIV cycles.
- `copi` is stable for DIV cycles before and DIV cycles after each `sclk` rising edge.
- Maximum throughput: one frame per 34·DIV+1 cycles.

## Test plan
- DIV=4; `wr`=1, `addr`=0x00, `data`=0xF0, `start` pulse. Required:
  - `copi` sampled at the 16 rising edges = 1000_0000_1111_0000.
  - `ncs` low for 132 cycles.
  - `done` pulse 136 cycles after accept.
- Loopback with the SPI peripheral on the same `clk`, DIV=4: write `addr`=0x04, `data`=0x80, then `addr`=0x02, `data`=0x3C. Required: `pwm_duty_cycle`=0x80 and `en_reg_pwm_7_0`=0x3C after the respective `done`.
- `wr`=0, `addr`=0x01, `data`=0xFF. Required: bit 15 sent as 0, and the peripheral's `en_reg_out_15_8` is unchanged.
- `start` held high continuously, with `addr`/`data` changed mid-frame. Required:
  - First frame carries the values latched at accept.
  - Next frame is accepted in the `done` cycle.
  - Back-to-back `ncs` high gap is at least DIV cycles.
- Assert `rst` after the 7th `sclk` rise. Required:
  - Next cycle: `ncs`=1, `sclk`=0, `busy`=0, `done`=0.
  - Peripheral registers unchanged.
  - A following frame completes normally.
- DIV=2 and DIV=7 runs. Required: 16 rising edges, `done` at 68 and 238 cycles after accept, respectively.
